clashup_out_tx: RTL
===================

# clashup_out_tx

Output serializer for the clashup CPU. It sits directly downstream of the CPU's 8-bit `out` register. Each byte the CPU emits with an OUT instruction is buffered in a small FIFO, then transmitted on a single UART line as 8N1 frames. This decouples the CPU's instruction rate from the serial bit rate.

## Interface

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥ 2
- CLKS_PER_BIT, 16, clk cycles per UART bit; ≥ 2

Ports:
- clk  in  1  single system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when rst == 0)
- out_data  in  8  byte from the CPU OUT path
- out_valid  in  1  one-cycle strobe per OUT instruction
- out_ready  out  1  = !full; a push is accepted only when out_valid && out_ready
- ovf_clr  in  1  clears the sticky overflow flag
- tx  out  1  UART line; idles high
- busy  out  1  1 whenever the TX FSM is not in IDLE
- count  out  $clog2(DEPTH)+1  FIFO occupancy; excludes the byte in the shifter
- overflow  out  1  sticky; set when out_valid arrives while full

## Operation

- FIFO
  - Circular buffer with rd/wr pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - Occupancy is held in `count`.
  - full = (count == DEPTH); empty = (count == 0).
- Push: on a clk edge with out_valid && !full, write out_data at wr_ptr and advance wr_ptr.
- Drop: out_valid while full discards the byte and sets overflow. No state other than overflow changes.
- Overflow flag:
  - ovf_clr clears overflow.
  - If a drop and ovf_clr occur in the same cycle, set wins.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - out_ready is computed from registered count only. A pop in the same cycle does not unblock a push while full.
- TX FSM states: IDLE, START, DATA, STOP.
  - Each bit lasts CLKS_PER_BIT cycles, timed by a baud counter.
  - IDLE: tx = 1. If !empty, pop the FIFO head into the shift register and go to START.
  - START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index = 0.
  - DATA: tx = shift[0], LSB first. After each bit period, shift right and increment the index. After bit 7, go to STOP.
  - STOP: tx = 1 for CLKS_PER_BIT cycles.
    - At the end of STOP, if !empty, pop and go directly to START (no idle gap).
    - Otherwise go to IDLE.
- tx is registered and glitch-free.
- Reset (async, any time, including mid-frame or mid-push):
  - tx = 1, busy = 0, count = 0, out_ready = 1, overflow = 0.
  - Pointers = 0, state = IDLE, baud counter = 0.
  - FIFO contents and any in-flight frame are discarded.
- Release: the first edge after rst returns high behaves as a normal cycle.

## Timing

- Push-to-line latency, with the FIFO empty and the FSM in IDLE:
  - Byte accepted at edge k.
  - Pop and START entry at edge k+1, so tx is low from k+1.
- Frame length: 10·CLKS_PER_BIT cycles.
  - Start bit occupies edges k+1 .. k+CLKS_PER_BIT.
  - busy falls at edge k+1+10·CLKS_PER_BIT.
- Back-to-back frames are contiguous: the next start bit begins on the edge the previous stop bit ends.
- count updates on the same edge as the push or pop.
- overflow asserts on the edge of the drop.
- out_ready reflects count after the previous edge.
- Sustained throughput: one byte per 10·CLKS_PER_BIT cycles. The CPU must not exceed this on average, or drops occur.

## Test plan

Unless noted, DEPTH=8 and CLKS_PER_BIT=4.

1. Reset values: hold rst=0 with random inputs → tx=1, busy=0, count=0, out_ready=1, overflow=0. Release rst; 20 idle cycles → tx stays 1.
2. Single byte 0xA5 pushed at edge k:
   - tx=0 on k+1..k+4.
   - Then bits 1,0,1,0,0,1,0,1, 4 cycles each.
   - Stop bit high for 4 cycles.
   - busy falls at k+41; count stays 0 throughout.
3. Overflow burst: push 0x10..0x19 on 10 consecutive edges.
   - 0x10 moves to the shifter at edge 1.
   - count reaches 8 after edge 8.
   - 0x19 is dropped at edge 9: overflow=1, out_ready=0.
   - Line carries 0x10..0x18 as 9 contiguous frames (360 cycles) with no idle gaps.
4. Overflow clear:
   - ovf_clr alone → overflow=0.
   - A drop and ovf_clr on the same edge → overflow stays 1.
5. Reset mid-frame: assert rst during DATA bit 3 with 4 bytes queued.
   - tx=1 and count=0 immediately, without waiting for clk.
   - After release, no further frames are emitted.
6. Pointer wrap: stream 24 bytes (0x00..0x17), each pushed when out_ready=1.
   - The receiver model decodes exactly 0x00..0x17 in order.
   - overflow stays 0; count never exceeds 8.

Source files
------------

// File: rtl/clashup_out_tx.sv
// Byte FIFO feeding an 8N1 UART transmitter; a byte pushed into an idle, empty unit starts its start bit one cycle later.
// Backpressure: out_ready = !full (registered count only); a strobe while full is dropped and sets sticky overflow.
module clashup_out_tx #(
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               out_data,
    input  logic                     out_valid,
    output logic                     out_ready,
    input  logic                     ovf_clr,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          drop;
    logic          pop;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] baud;
    logic          baud_end;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    shift_nxt;
    logic          tx_nxt;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign push      = out_valid && !full;
    assign drop      = out_valid && full;
    assign out_ready = !full;
    assign busy      = (state != IDLE);
    assign baud_end  = (baud == BW'(CLKS_PER_BIT - 1));

    // Storage carries no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= out_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state <= state_nxt;
            shift <= shift_nxt;
            tx    <= tx_nxt;
            baud  <= (state == IDLE || baud_end) ? '0 : baud + 1'b1;
            if (state == START && baud_end) begin
                bit_idx <= '0;
            end else if (state == DATA && baud_end) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = START;
                    pop       = 1'b1;
                end
            end
            START: begin
                if (baud_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (baud_end && bit_idx == 3'd7) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // Chain straight into the next start bit when more data waits.
                if (baud_end) begin
                    if (!empty) begin
                        state_nxt = START;
                        pop       = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // tx is computed from the next state so the line itself is a flop output.
    always_comb begin
        shift_nxt = shift;
        tx_nxt    = 1'b1;
        if (pop) begin
            shift_nxt = mem[rd_ptr];
        end else if (state == DATA && baud_end) begin
            shift_nxt = {1'b0, shift[7:1]};
        end
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end

endmodule
